// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and small decode helpers for the data memory.
package dmem_pkg;

  // RV32 load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Misalignment, unknown width codes, and unsigned widths used for stores
  // are all rejected.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic err;
    err = 1'b0;
    case (f3)
      F3_B:  err = 1'b0;
      F3_H:  err = lo[0];
      F3_W:  err = (lo != 2'b00);
      F3_BU: err = we;
      F3_HU: err = we | lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Byte lanes touched by a store of the given width at the given offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      F3_B, F3_BU: m = 4'b0001 << lo;
      F3_H, F3_HU: m = lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Combinational lane select and sign/zero extension for load data.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend according to the width code.
  always_comb begin
    byte_sel = word[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    data     = 32'h0;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_W:    data = word;
      F3_BU:   data = {24'h0, byte_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// Word-organised data memory with byte-lane stores behind a valid/ready
// request/response handshake; optional zeroing sweep after reset.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where resp_valid && resp_ready. Once
// resp_valid is high, resp_rdata/resp_err stay constant until that transfer.
module data_mem_hs
  import dmem_pkg::*;
#(
  parameter int MEM_SIZE       = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  init_done,
  output state_e                dbg_state
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_SIZE - 1);
  localparam state_e RESET_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e state_q, state_d;
  logic [IDX_W-1:0]      clr_idx_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [31:0] mem [MEM_SIZE];
  logic [31:0] rd_q;

  logic             err;
  logic             accept;
  logic             mem_we;
  logic             mem_re;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic [31:0]      fmt_data;

  assign accept = req_valid && req_ready;
  assign err    = access_err(we_q, f3_q, addr_q[1:0]);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_ST;
    else        state_q <= state_d;
  end

  // Next-state: sweep, wait for request, one access cycle, hold response
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR:  if (clr_idx_q == LAST_IDX) state_d = ST_IDLE;
      ST_IDLE:   if (req_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = RESET_ST;
    endcase
  end

  // Clear sweep index; wraps back to 0 as the sweep finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  clr_idx_q <= '0;
    else if (state_q == ST_CLEAR) clr_idx_q <= clr_idx_q + 1'b1;
  end

  // Capture the accepted request so it stays stable through ACCESS and RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= F3_W;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Array port mux: the clear sweep owns the port while in CLEAR
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_idx   = addr_q[IDX_W+1:2];
    mem_be    = lane_mask(f3_q, addr_q[1:0]);
    mem_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00:   mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx_q;
      mem_be    = 4'b1111;
      mem_wdata = 32'h0;
    end else if (state_q == ST_ACCESS && !err) begin
      mem_we = we_q;
      mem_re = !we_q;
    end
  end

  // Single-port array with byte-lane writes and registered read (no reset)
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    if (mem_re) rd_q <= mem[mem_idx];
  end

  dmem_load_fmt u_fmt (
    .word    (rd_q),
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .data    (fmt_data)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = (state_q == ST_RESP) && err;
  assign resp_rdata = (state_q == ST_RESP && !we_q && !err) ? fmt_data : 32'h0;
  assign init_done  = (state_q != ST_CLEAR);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench for data_mem_hs (MEM_SIZE=16, clear on reset).
module tb_data_mem_hs;
  import dmem_pkg::*;

  localparam int MEM_SIZE  = 16;
  localparam int MEM_BYTES = MEM_SIZE * 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;
  state_e      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mb [MEM_BYTES];
  logic [32:0] exp_q [$];
  logic [31:0] got;

  data_mem_hs #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_done  (init_done),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte-addressed store, address taken modulo the array size.
  function automatic logic [32:0] model_resp(input logic we, input logic [2:0] f3,
                                             input logic [31:0] addr);
    int size;
    bit sgn;
    bit legal;
    int base;
    longint v;
    size = 1; sgn = 0; legal = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 0; end
      3'd4: begin size = 1; sgn = 0; if (we) legal = 0; end
      3'd5: begin size = 2; sgn = 0; if (we) legal = 0; end
      default: legal = 0;
    endcase
    base = int'(addr % MEM_BYTES);
    if (legal && (base % size) != 0) legal = 0;
    if (!legal) return {1'b1, 32'h0};
    if (we) return {1'b0, 32'h0};
    v = 0;
    for (int k = 0; k < size; k++) v = v + (longint'(mb[base + k]) << (8 * k));
    if (sgn && size < 4 && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
    return {1'b0, 32'(v)};
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int size;
    int base;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    base = int'(addr % MEM_BYTES);
    for (int k = 0; k < size; k++) mb[base + k] = 8'(wdata >> (8 * k));
  endtask

  task automatic model_clear();
    for (int i = 0; i < MEM_BYTES; i++) mb[i] = 8'h00;
  endtask

  // Asserts reset, checks outputs, releases it and times the clear sweep.
  task automatic do_reset();
    int cnt;
    rst_n = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_CLEAR));
    tick();
    tick();
    rst_n = 1'b1;
    model_clear();
    cnt = 0;
    while (!init_done && cnt < 200) begin
      tick();
      cnt++;
    end
    check("clear_cycles", 32'(cnt), 32'(MEM_SIZE));
    check("ready_after_clear", 32'(req_ready), 32'd1);
  endtask

  // Driver: one full request/response transaction with optional response stall.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, output logic [31:0] rdata);
    logic [32:0] exp;
    int cnt;
    rdata = 32'h0;
    exp_q.push_back(model_resp(we, f3, addr));
    cnt = 0;
    while (!req_ready && cnt < 100) begin
      tick();
      cnt++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_wdata = $urandom;
    check("access_no_resp", 32'(resp_valid), 32'd0);
    tick();
    exp = exp_q.pop_front();
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_err", 32'(resp_err), 32'(exp[32]));
    check("resp_rdata", resp_rdata, exp[31:0]);
    rdata = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp[31:0]);
      check("hold_ready_low", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("post_hs_valid", 32'(resp_valid), 32'd0);
    check("post_hs_idle", 32'(req_ready), 32'd1);
    if (we && !exp[32]) model_store(f3, addr, wdata);
  endtask

  initial begin
    logic [2:0] f3;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    do_reset();

    do_req(1'b0, F3_W, 32'h3C, 32'h0, 0, got);
    check("lw_3c_zero", got, 32'h0);

    do_req(1'b1, F3_W, 32'h10, 32'h8000_00FF, 0, got);
    do_req(1'b0, F3_B, 32'h10, 32'h0, 0, got);
    check("lb_10", got, 32'hFFFF_FFFF);
    do_req(1'b0, F3_BU, 32'h13, 32'h0, 0, got);
    check("lbu_13", got, 32'h0000_0080);
    do_req(1'b0, F3_H, 32'h12, 32'h0, 0, got);
    check("lh_12", got, 32'hFFFF_8000);
    do_req(1'b0, F3_HU, 32'h10, 32'h0, 0, got);
    check("lhu_10", got, 32'h0000_00FF);

    do_req(1'b1, F3_W, 32'h20, 32'h1122_3344, 0, got);
    do_req(1'b1, F3_B, 32'h21, 32'h0000_00AA, 0, got);
    do_req(1'b0, F3_W, 32'h20, 32'h0, 0, got);
    check("lw_20_merge", got, 32'h1122_AA44);

    do_req(1'b0, F3_W, 32'h22, 32'h0, 0, got);
    do_req(1'b1, F3_H, 32'h01, 32'hFFFF_FFFF, 0, got);
    do_req(1'b0, F3_W, 32'h00, 32'h0, 0, got);
    check("sh_err_no_write", got, 32'h0);
    do_req(1'b1, F3_BU, 32'h04, 32'hFFFF_FFFF, 0, got);
    do_req(1'b0, 3'b011, 32'h00, 32'h0, 0, got);

    do_req(1'b0, F3_W, 32'h10, 32'h0, 5, got);
    check("stall_lw_10", got, 32'h8000_00FF);

    do_req(1'b1, F3_W, 32'h40, 32'hCAFE_BABE, 0, got);
    do_req(1'b0, F3_W, 32'h00, 32'h0, 0, got);
    check("alias_lw_00", got, 32'hCAFE_BABE);

    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B;
          1: f3 = F3_H;
          2: f3 = F3_W;
          3: f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end
      do_req(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom_range(0, 3), got);
    end

    // Reset during RESP: response disappears at once and the sweep restarts.
    while (!req_ready) tick();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
    do_reset();
    do_req(1'b0, F3_W, 32'h00, 32'h0, 0, got);
    check("after_reclear_lw_00", got, 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_hs.md
DATA_MEM_HS -- requirements
Module: data_mem_hs

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 256: depth in 32-bit words; power of two, 4..65536.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte-address width.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero the array after reset, 0 = skip the clear.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1: request offered.
REQ-007 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready at the edge.
REQ-008 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_funct3, input, 3: RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH: byte address.
REQ-011 SHALL have port req_wdata, input, 32: store data; low bits used for b/h.
REQ-012 SHALL have port resp_valid, output, 1: response present.
REQ-013 SHALL have port resp_ready, input, 1: response consumed when resp_valid && resp_ready at the edge.
REQ-014 SHALL have port resp_rdata, output, 32: formatted load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err, output, 1: misaligned access or illegal funct3.
REQ-016 SHALL have port init_done, output, 1: high once the post-reset clear has completed.

Function
REQ-017 SHALL implement FSM states CLEAR, IDLE, ACCESS, RESP.
REQ-018 SHALL leave reset in CLEAR if CLEAR_ON_RESET=1; otherwise SHALL leave reset in IDLE with init_done=1.
REQ-019 CLEAR SHALL write 0 to word index 0..MEM_SIZE-1, one word per cycle; after index MEM_SIZE-1 it SHALL go to IDLE and set init_done=1; req_ready=0 throughout.
REQ-020 SHALL drive req_ready=1 only in IDLE; acceptance SHALL register we/funct3/addr/wdata and go to ACCESS.
REQ-021 SHALL form the word index as addr[log2(MEM_SIZE)+1:2], which wraps modulo MEM_SIZE; upper address bits SHALL be ignored.
REQ-022 SHALL flag an error when: h/hu with addr[0]=1; w with addr[1:0]!=0; or funct3 in {011,110,111}, or funct3 in {100,101} with we=1.
REQ-023 ACCESS SHALL last exactly one cycle: load = synchronous array read into a data register; store = byte-lane masked write (sb 1 lane, sh 2 lanes, sw 4) leaving unselected lanes unchanged; error = no array write.
REQ-024 ACCESS SHALL always go to RESP, giving request-accept to resp_valid latency = 2 cycles.
REQ-025 In RESP, resp_valid=1, resp_rdata and resp_err SHALL be held stable until resp_ready; on handshake the FSM SHALL go to IDLE with no back-to-back bypass (max throughput 1 request per 3 cycles).
REQ-026 Load formatting: b/h sign-extend and bu/hu zero-extend the selected lane(s) (lane = addr[1:0], half = addr[1]); w passes the word unchanged.
REQ-027 resp_rdata SHALL be 0 when resp_err=1 or the access is a store.
REQ-028 A load accepted after a store to the same word SHALL return the post-store value.

Reset
REQ-029 Reset assertion SHALL asynchronously force state CLEAR (or IDLE), req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0 (or 1 when CLEAR_ON_RESET=0), clear index=0.
REQ-030 Reset mid-ACCESS or mid-RESP SHALL drop the in-flight request with no response; a store that has not yet reached its ACCESS edge SHALL NOT be written.
REQ-031 Array contents SHALL NOT be reset asynchronously; only the CLEAR sweep initialises them.

Structure
REQ-032 Package dmem_pkg SHALL hold the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state enum.
REQ-033 Sub-module dmem_load_fmt SHALL be the combinational lane select and sign/zero extension (inputs word, funct3, addr[1:0]).
REQ-034 The array SHALL be a single-port, 32-bit-wide memory inferable as block RAM with byte-lane writes.

Verification
REQ-035 Reset with MEM_SIZE=16, CLEAR_ON_RESET=1 -> init_done rises after exactly 16 cycles in CLEAR; lw at 0x3C then returns 0x00000000.
REQ-036 sw 0x8000_00FF at 0x10, then lb 0x10 -> 0xFFFFFFFF; lbu 0x13 -> 0x00000080; lh 0x12 -> 0xFFFF8000; lhu 0x10 -> 0x000000FF.
REQ-037 sw 0x11223344 at 0x20, then sb 0xAA at 0x21 -> lw 0x20 returns 0x1122AA44.
REQ-038 lw at 0x22 and sh at 0x01 -> resp_err=1, resp_rdata=0, and memory is unchanged.
REQ-039 Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready=0; release -> IDLE on the next cycle.
REQ-040 With MEM_SIZE=16, sw at 0x40 aliases word 0, so lw 0x00 returns the stored value; rst_n pulsed during RESP -> no response, CLEAR restarts.
